card_frame_rx: RTL and testbench
================================

# card_frame_rx

Serial front end for the metro turnstile controller. Deserialises bit-strobed frames from the contactless card reader PHY into a 4-bit access code. Checks start, parity and stop bits and a per-bit timeout. Presents `access_code` with a one-cycle `valid_code` pulse to the downstream turnstile FSM, and accepts only one code per card tap.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum clock cycles allowed between consecutive bit strobes inside a frame; must be ≥ 2.
- `TW`, default `$clog2(TIMEOUT_CYCLES+1)`: timeout counter width (derived; do not override).

Ports (reset is `reset`, asynchronous, active-low; clock is `clk`):
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: asynchronous active-low reset.
- `card_present` input 1: level, high while a card is in the reader field.
- `card_bit_strobe` input 1: one-cycle pulse; `card_data` is valid in this cycle.
- `card_data` input 1: serial frame bit.
- `access_code` output 4: last accepted code; held stable between accepts.
- `valid_code` output 1: one-cycle pulse when `access_code` is newly updated.
- `frame_error` output 1: one-cycle pulse on any rejected frame.
- `busy` output 1: high in every state other than IDLE.
- `rx_state` output 3: current state encoding, for debug.

## Operation
- Frame format, one bit per strobe: start bit = 1, then data d3..d0 (MSB first), then parity p (even: d3^d2^d1^d0^p = 0), then stop bit = 0.
- Strobes are sampled only while `card_present` = 1.
- States:
  - IDLE (0): a strobe with data = 1 goes to DATA and clears bit_cnt. A strobe with data = 0 is ignored, stays in IDLE, no error.
  - DATA (1): each strobe shifts the bit into shift_reg[3:0]. The 4th strobe (bit_cnt = 3) goes to PARITY.
  - PARITY (2): a strobe captures p and goes to STOP.
  - STOP (3): a strobe with data = 0 and parity good goes to HOLD. `access_code` is loaded from shift_reg and `valid_code` is pulsed. A bad stop bit or bad parity goes to HOLD and pulses `frame_error`.
  - HOLD (4): waits for `card_present` = 0, then goes to IDLE. Strobes are ignored, so one code per tap.
- Abort: `card_present` = 0 while in DATA, PARITY or STOP goes to IDLE and pulses `frame_error`. Abort wins over a simultaneous strobe.
- Timeout: in DATA, PARITY or STOP, the timer clears on every strobe and increments otherwise. When the timer reaches `TIMEOUT_CYCLES` with no strobe, the block goes to HOLD and pulses `frame_error`. The timer saturates and never wraps. The timer is 0 in IDLE and HOLD.
- HOLD with `card_present` already 0 exits to IDLE on the next edge.
- Encodings 5–7 of `rx_state` are illegal and recover to IDLE.

## Timing
- Reset values: `access_code` = 0, `valid_code` = 0, `frame_error` = 0, `busy` = 0, `rx_state` = 0 (IDLE); internal shift_reg, bit_cnt and timer are 0.
- All outputs are registered.
- `valid_code` / `frame_error` rise on the edge that samples the stop-bit strobe (or the abort/timeout condition). They are high for exactly one cycle.
- `access_code` changes on that same edge and then stays constant until the next accepted frame. This guarantees the downstream FSM sees a stable code in the cycle after `valid_code`.
- `valid_code` and `frame_error` are never high together.
- Minimum frame time is 7 strobes. Strobes may arrive on back-to-back cycles.
- Reset asserted mid-frame: immediate return to IDLE. `access_code` clears to 0 and no pulse is emitted.

## Structure
- Shared package `metro_pkg` holds:
  - state localparams `RX_IDLE`..`RX_HOLD` (3 bits);
  - `START_BIT` = 1, `STOP_BIT` = 0, `CODE_W` = 4.
  - The turnstile FSM imports `CODE_W` from the same package.
- Single module with no sub-modules: the timeout counter and shift register are small enough to stay inline.

## Test plan
- Frame for code 6: strobes 1,0,1,1,0,0,0 → `valid_code` pulse one cycle after the last strobe, `access_code` = 4'd6, no `frame_error`, state HOLD. Drop `card_present` → IDLE.
- Frame for code 7 (bits 1,0,1,1,1,1,0) sent with wrong parity 0 → `frame_error` pulse, `access_code` keeps its previous value, state HOLD.
- Start of frame, then a gap of `TIMEOUT_CYCLES` = 64 cycles after the 2nd data bit → `frame_error` on cycle 64, state HOLD. A strobe at cycle 63 instead clears the timer and the frame continues.
- `card_present` falls in the same cycle as the parity strobe → abort, `frame_error` pulse, state IDLE, no `valid_code`.
- After a valid code 6, a second full frame for code 11 is sent without card removal → ignored, `access_code` stays 6. After removal and re-tap → `access_code` = 11.
- `reset` asserted low during DATA → all outputs 0 immediately. A leading 0 strobe in IDLE → stays in IDLE, no error.

Source files
------------

// File: rtl/metro_pkg.sv
// Shared definitions for the metro turnstile datapath.
// Holds the card receiver state encodings, frame framing constants and the
// access-code width that the turnstile FSM also imports.
package metro_pkg;

  localparam int CODE_W = 4;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_DATA   = 3'd1;
  localparam logic [2:0] RX_PARITY = 3'd2;
  localparam logic [2:0] RX_STOP   = 3'd3;
  localparam logic [2:0] RX_HOLD   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = RX_IDLE,
    ST_DATA   = RX_DATA,
    ST_PARITY = RX_PARITY,
    ST_STOP   = RX_STOP,
    ST_HOLD   = RX_HOLD
  } rx_state_t;

  // Even parity over data plus parity bit: true when the XOR of all is zero.
  function automatic logic parity_ok(input logic [CODE_W-1:0] d, input logic p);
    return ~((^d) ^ p);
  endfunction

endpackage

// File: rtl/card_frame_rx.sv
// card_frame_rx: deserialises strobed card-reader frames into a 4-bit access
// code. Frame = start(1), d3..d0, even parity, stop(0). One code per tap.
// Ports:
//   clk             - clock, rising edge
//   reset           - asynchronous active-low reset
//   card_present    - high while a card is in the field
//   card_bit_strobe - one-cycle strobe qualifying card_data
//   card_data       - serial frame bit
//   access_code     - last accepted code, stable between accepts
//   valid_code      - one-cycle pulse when access_code is updated
//   frame_error     - one-cycle pulse on a rejected/aborted/timed-out frame
//   busy            - high whenever the receiver is not idle
//   rx_state        - current state encoding (debug)
module card_frame_rx
  import metro_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              card_present,
  input  logic              card_bit_strobe,
  input  logic              card_data,
  output logic [CODE_W-1:0] access_code,
  output logic              valid_code,
  output logic              frame_error,
  output logic              busy,
  output logic [2:0]        rx_state
);

  rx_state_t         state_q, state_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              par_q, par_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [TW-1:0]     timer_inc;
  logic              timeout_hit;

  // Saturating increment; the timeout fires on the edge the count would
  // reach TIMEOUT_CYCLES, i.e. after TIMEOUT_CYCLES strobe-free edges.
  assign timer_inc   = (timer_q == TW'(TIMEOUT_CYCLES)) ? timer_q : timer_q + TW'(1);
  assign timeout_hit = (timer_inc == TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    timer_d = '0;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (card_present && card_bit_strobe && card_data == START_BIT) begin
          state_d = ST_DATA;
          cnt_d   = 2'd0;
        end
      end
      ST_DATA, ST_PARITY, ST_STOP: begin
        // Card removal aborts the frame even if a strobe arrives with it.
        if (!card_present) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (card_bit_strobe) begin
          if (state_q == ST_DATA) begin
            shift_d = {shift_q[CODE_W-2:0], card_data};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = ST_PARITY;
          end else if (state_q == ST_PARITY) begin
            par_d   = card_data;
            state_d = ST_STOP;
          end else begin
            state_d = ST_HOLD;
            if (card_data == STOP_BIT && parity_ok(shift_q, par_q)) begin
              code_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (timeout_hit) begin
          state_d = ST_HOLD;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_HOLD: begin
        if (!card_present) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      timer_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign access_code = code_q;
  assign valid_code  = valid_q;
  assign frame_error = err_q;
  assign busy        = busy_q;
  assign rx_state    = state_q;

endmodule

// File: tb/tb_card_frame_rx.sv
// Randomised scoreboard bench for card_frame_rx. A frame-level reference model
// collects bits per tap and pushes expected pulses; a monitor pops on pulses.
module tb_card_frame_rx;

  localparam int TO = 64;

  logic       clk;
  logic       reset;
  logic       card_present;
  logic       card_bit_strobe;
  logic       card_data;
  logic [3:0] access_code;
  logic       valid_code;
  logic       frame_error;
  logic       busy;
  logic [2:0] rx_state;

  card_frame_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .card_present(card_present),
    .card_bit_strobe(card_bit_strobe), .card_data(card_data),
    .access_code(access_code), .valid_code(valid_code),
    .frame_error(frame_error), .busy(busy), .rx_state(rx_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       is_err;
    bit [3:0] code;
    int       cyc;
  } exp_t;
  exp_t sb[$];

  bit       m_in_frame = 0;
  bit       m_locked   = 0;
  bit       m_bits[$];
  int       m_gap      = 0;
  bit [3:0] m_code     = 0;

  function automatic void push_exp(input bit is_err, input bit [3:0] code);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.cyc    = cyc + 1;
    sb.push_back(e);
  endfunction

  // Effect of the coming clock edge given the inputs applied for it.
  function automatic void model_step(input bit p, input bit s, input bit d);
    bit [3:0] code;
    int ones;
    if (m_locked) begin
      if (!p) m_locked = 0;
    end else if (!m_in_frame) begin
      if (p && s && d) begin
        m_in_frame = 1;
        m_bits.delete();
        m_gap = 0;
      end
    end else if (!p) begin
      push_exp(1, 0);
      m_in_frame = 0;
    end else if (s) begin
      m_bits.push_back(d);
      m_gap = 0;
      if (m_bits.size() == 6) begin
        code = {m_bits[0], m_bits[1], m_bits[2], m_bits[3]};
        ones = 0;
        for (int i = 0; i < 5; i++) ones += m_bits[i];
        if (m_bits[5] == 0 && (ones % 2) == 0) begin
          push_exp(0, code);
          m_code = code;
        end else begin
          push_exp(1, 0);
        end
        m_in_frame = 0;
        m_locked   = 1;
      end
    end else begin
      m_gap++;
      if (m_gap == TO) begin
        push_exp(1, 0);
        m_in_frame = 0;
        m_locked   = 1;
      end
    end
  endfunction

  function automatic int exp_state();
    if (m_locked) return 4;
    if (m_in_frame) begin
      if (m_bits.size() < 4) return 1;
      if (m_bits.size() == 4) return 2;
      return 3;
    end
    return 0;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("access_code", access_code, m_code);
      chk("busy", busy, (m_in_frame || m_locked) ? 1 : 0);
      chk("rx_state", rx_state, exp_state());
      if (valid_code && frame_error) chk("pulse_exclusive", 1, 0);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("missed_pulse_cycle", cyc, e.cyc);
      end
      if (valid_code || frame_error) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse_err", frame_error, 0);
          chk("unexpected_pulse_vld", valid_code, 0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind_err", frame_error, e.is_err);
          chk("pulse_cycle", cyc, e.cyc);
          if (!e.is_err) chk("pulse_code", access_code, e.code);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit p, input bit s, input bit d);
    @(negedge clk);
    #1;
    card_present    = p;
    card_bit_strobe = s;
    card_data       = d;
    model_step(p, s, d);
  endtask

  task automatic idle(input int n, input bit p);
    for (int i = 0; i < n; i++) step(p, 0, 0);
  endtask

  function automatic void make_frame(input bit [3:0] code, input bit bad_par,
                                     input bit bad_stop, output bit f[$]);
    f.delete();
    f.push_back(1);
    for (int i = 3; i >= 0; i--) f.push_back(code[i]);
    f.push_back((^code) ^ bad_par);
    f.push_back(bad_stop);
  endfunction

  task automatic send(input bit [3:0] code, input bit bad_par, input bit bad_stop);
    bit f[$];
    make_frame(code, bad_par, bad_stop, f);
    foreach (f[i]) step(1, 1, f[i]);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1;
    card_present = 0; card_bit_strobe = 0; card_data = 0;
    reset = 0;
    #1;
    chk("rst_access_code", access_code, 0);
    chk("rst_valid_code", valid_code, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_state", rx_state, 0);
    m_in_frame = 0; m_locked = 0; m_code = 0; m_gap = 0;
    m_bits.delete();
    repeat (2) @(negedge clk);
    #1;
    reset = 1;
    model_step(0, 0, 0);
  endtask

  task automatic rand_tap();
    bit f[$];
    bit [3:0] code;
    int abort_at;
    code = 4'($urandom_range(0, 15));
    make_frame(code, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, f);
    abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : -1;
    idle($urandom_range(0, 2), 1);
    foreach (f[i]) begin
      if (i > 0) begin
        if ($urandom_range(0, 29) == 0) idle(TO + $urandom_range(0, 4) - 2, 1);
        else if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3), 1);
      end
      if (i == abort_at) begin
        step(0, 1'($urandom_range(0, 1)), f[i]);
        break;
      end
      step(1, 1, f[i]);
    end
    for (int i = 0; i < $urandom_range(0, 3); i++)
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < $urandom_range(1, 3); i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    reset = 1; card_present = 0; card_bit_strobe = 0; card_data = 0;
    #2 reset = 0;
    #1;
    chk("init_access_code", access_code, 0);
    chk("init_valid_code", valid_code, 0);
    chk("init_frame_error", frame_error, 0);
    chk("init_busy", busy, 0);
    chk("init_rx_state", rx_state, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1;
    model_step(0, 0, 0);

    // code 6, then removal
    idle(2, 1);
    send(4'd6, 0, 0);
    idle(2, 1);
    idle(2, 0);
    // code 7 with wrong parity
    send(4'd7, 1, 0);
    idle(1, 1);
    idle(2, 0);
    // timeout after 2nd data bit
    step(1, 1, 1); step(1, 1, 0); step(1, 1, 1);
    idle(TO, 1);
    idle(2, 1);
    idle(2, 0);
    // strobe on the 63rd gap cycle keeps the frame alive (code 5)
    step(1, 1, 1); step(1, 1, 0); step(1, 1, 1);
    idle(TO - 2, 1);
    step(1, 1, 0); step(1, 1, 1); step(1, 1, 0); step(1, 1, 0);
    idle(2, 0);
    // abort together with parity strobe
    step(1, 1, 1); step(1, 1, 1); step(1, 1, 1); step(1, 1, 0); step(1, 1, 0);
    step(0, 1, 0);
    idle(2, 0);
    // one code per tap: 6 accepted, 11 ignored, re-tap gives 11
    send(4'd6, 0, 0);
    send(4'd11, 0, 0);
    idle(2, 0);
    send(4'd11, 0, 0);
    idle(2, 0);
    // reset mid-frame
    step(1, 1, 1); step(1, 1, 1); step(1, 1, 0);
    reset_pulse();
    // leading zero strobes ignored, then code 9
    step(1, 1, 0); step(1, 1, 0);
    send(4'd9, 0, 0);
    idle(2, 0);
    // bad stop bit
    send(4'd3, 0, 1);
    idle(2, 0);
    // randomised taps
    for (int t = 0; t < 60; t++) rand_tap();
    idle(3, 0);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
